arb_requester: RTL
==================

// Module: arb_requester
// PURPOSE
//  Client-side agent for one port of the 4-way round-robin arbiter (drives reqN, consumes ackN).
//  - Queues burst jobs from local logic.
//  - Holds req high until every beat of the burst has been granted; one ack = one beat.
//  - Presents beat data for the downstream bus mux, which selects on ack.
//  - Flags starvation when ack is withheld too long.
// PARAMETERS
//  DW     8   beat/bus data width
//  DEPTH  4   job FIFO entries (power of 2, >=2)
//  LENW   4   job length field width; beats per job = job_len+1 (1..2^LENW)
//  TMO    15  consecutive un-acked req cycles before a starve pulse (>=1)
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous, active-low reset
//  job_valid  in   1        job offered
//  job_ready  out  1        job FIFO not full; push when job_valid&job_ready at clk edge
//  job_data   in   DW       base data of job
//  job_len    in   LENW     beats-1
//  req        out  1        request to arbiter port
//  ack        in   1        grant from arbiter (combinational in arbiter, sampled at clk edge)
//  bus_data   out  DW       current beat data, valid while req=1
//  bus_last   out  1        current beat is final beat of job, valid while req=1
//  busy       out  1        FSM in REQ or FIFO non-empty
//  starve     out  1        one-cycle pulse on timeout
//  starve_cnt out  8        saturating count of starve pulses
// BEHAVIOUR
//  Reset (async, rst_n=0):
//  - FIFO empty; FSM=IDLE; req=0, bus_data=0, bus_last=0, busy=0, starve=0, starve_cnt=0.
//  - Internal wait counter, beat counter and FIFO pointers all cleared.
//  - Reset mid-burst drops the current job and all queued jobs; no partial state survives.
//  Job FIFO:
//  - job_ready=!full. A push is refused when full, even if a pop occurs on the same edge.
//  - Push and pop on the same edge are both performed when not full; pointers wrap mod DEPTH.
//  FSM:
//  - IDLE: req=0. If FIFO non-empty at an edge -> pop head into {base,len}, beat=0, go REQ.
//      A push sampled at edge k therefore gives req=1 from edge k+1.
//  - REQ: req=1, bus_data=base+beat (mod 2^DW), bus_last=(beat==len).
//      ack=1 && !bus_last -> beat<=beat+1 (stay REQ).
//      ack=1 && bus_last && FIFO non-empty -> pop next job, beat=0, stay REQ.
//          req stays high with no bubble (back-to-back jobs).
//      ack=1 && bus_last && FIFO empty -> IDLE; req=0 from the next cycle.
//      ack=0 -> hold all outputs.
//  - ack while req=0 (IDLE) is ignored.
//  Starvation:
//  - wait counter increments each REQ cycle with ack=0 and clears on ack or in IDLE.
//  - When the counter reaches TMO: starve=1 for one cycle, counter<=0, starve_cnt+1.
//      starve_cnt saturates at 255.
//  - req is never dropped because of a timeout.
//  busy=(state==REQ)||!empty.
// TESTING
//  1 Reset: hold rst_n=0, toggle job_valid/ack -> all outputs 0, job_ready=1.
//      Release rst_n -> still idle.
//  2 Single job data=8'hF E, len=2, ack held high -> req=1 for exactly 3 cycles.
//      bus_data FE,FF,00; bus_last on the 3rd beat; then IDLE.
//  3 Push 5 jobs with no ack (DEPTH=4) -> 1st loaded, next 4 fill the FIFO.
//      job_ready=0 after the 5th push; a 6th push is refused.
//  4 Two queued jobs (len=0, len=1), ack=1 -> req stays high for 3 consecutive cycles.
//      bus_last on cycles 1 and 3.
//  5 req high, ack=0 for 31 cycles (TMO=15) -> starve pulses at cycles 15 and 30.
//      starve_cnt=2; ack then completes the job normally.
//  6 rst_n low mid-burst (beat 1 of len=3) -> req=0 immediately; queued jobs lost.
//      After release: busy=0, job_ready=1.

Source files
------------

// File: rtl/arb_requester_if.sv
// Job-side and arbiter-side signals of one round-robin arbiter client port.
interface arb_requester_if #(
   parameter int unsigned DW   = 8,
   parameter int unsigned LENW = 4
);
   logic            job_valid;
   logic            job_ready;
   logic [DW-1:0]   job_data;
   logic [LENW-1:0] job_len;
   logic            req;
   logic            ack;
   logic [DW-1:0]   bus_data;
   logic            bus_last;
   logic            busy;
   logic            starve;
   logic [7:0]      starve_cnt;

   modport master (
      input  job_valid, job_data, job_len, ack,
      output job_ready, req, bus_data, bus_last, busy, starve, starve_cnt
   );

   modport slave (
      output job_valid, job_data, job_len, ack,
      input  job_ready, req, bus_data, bus_last, busy, starve, starve_cnt
   );
endinterface

// File: rtl/arb_requester.sv
// Client agent for one arbiter port: queues burst jobs, requests until every beat
// is acked, presents beat data, and flags starvation on long grant droughts.
module arb_requester #(
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned LENW  = 4,
   parameter int unsigned TMO   = 15
) (
   input logic            clk,
   input logic            rst_n,
   arb_requester_if.master bus_if
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = $clog2(TMO + 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_REQ  = 1'b1;

   typedef struct packed {
      logic [DW-1:0]   data;
      logic [LENW-1:0] len;
   } job_t;

   job_t            fifo_q [DEPTH];
   logic [0:0]      state_q, state_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [DW-1:0]   base_q, base_d;
   logic [LENW-1:0] len_q, len_d, beat_q, beat_d;
   logic [TW-1:0]   wait_q, wait_d;
   logic            starve_q, starve_d;
   logic [7:0]      starve_cnt_q, starve_cnt_d;
   logic [DW-1:0]   bus_data_q, bus_data_d;
   logic            bus_last_q, bus_last_d;
   logic            busy_q, busy_d;
   logic            ready_q, ready_d;
   logic            full, empty, push, pop, last;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign push  = bus_if.job_valid && !full;
   assign last  = (beat_q == len_q);

   // Next-state: FSM, FIFO pop/push bookkeeping, starvation timer, output images
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      base_d       = base_q;
      len_d        = len_q;
      beat_d       = beat_q;
      wait_d       = wait_q;
      starve_d     = 1'b0;
      starve_cnt_d = starve_cnt_q;
      pop          = 1'b0;

      case (state_q)
         S_IDLE: begin
            wait_d = '0;
            if (!empty) begin
               pop     = 1'b1;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (bus_if.ack) begin
               wait_d = '0;
               if (!last) begin
                  beat_d = beat_q + LENW'(1);
               end else if (!empty) begin
                  pop = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (wait_q == TW'(TMO - 1)) begin
               starve_d = 1'b1;
               wait_d   = '0;
               if (starve_cnt_q != 8'hFF) starve_cnt_d = starve_cnt_q + 8'd1;
            end else begin
               wait_d = wait_q + TW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (pop) begin
         base_d   = fifo_q[rd_ptr_q].data;
         len_d    = fifo_q[rd_ptr_q].len;
         beat_d   = '0;
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);

      bus_data_d = base_d + DW'(beat_d);
      bus_last_d = (beat_d == len_d);
      busy_d     = (state_d == S_REQ) || (count_d != '0);
      ready_d    = (count_d != CW'(DEPTH));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         base_q       <= '0;
         len_q        <= '0;
         beat_q       <= '0;
         wait_q       <= '0;
         starve_q     <= 1'b0;
         starve_cnt_q <= '0;
         bus_data_q   <= '0;
         bus_last_q   <= 1'b0;
         busy_q       <= 1'b0;
         ready_q      <= 1'b1;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         base_q       <= base_d;
         len_q        <= len_d;
         beat_q       <= beat_d;
         wait_q       <= wait_d;
         starve_q     <= starve_d;
         starve_cnt_q <= starve_cnt_d;
         bus_data_q   <= bus_data_d;
         bus_last_q   <= bus_last_d;
         busy_q       <= busy_d;
         ready_q      <= ready_d;
      end
   end

   // Payload storage needs no reset; validity is carried by the pointers
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr_q].data <= bus_if.job_data;
         fifo_q[wr_ptr_q].len  <= bus_if.job_len;
      end
   end

   assign bus_if.req        = (state_q == S_REQ);
   assign bus_if.job_ready  = ready_q;
   assign bus_if.bus_data   = bus_data_q;
   assign bus_if.bus_last   = bus_last_q;
   assign bus_if.busy       = busy_q;
   assign bus_if.starve     = starve_q;
   assign bus_if.starve_cnt = starve_cnt_q;
endmodule
